// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: clear, write ports, read ports and the collision flag.
// There is no handshake: every write with wr_en high commits at the next edge, and reads never stall.
interface regfile_mp_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
);
    logic                     clr;
    logic [NWRITE-1:0]        wr_en;
    logic [NWRITE*ADDR_W-1:0] wr_addr;
    logic [NWRITE*WIDTH-1:0]  wr_data;
    logic [NREAD*ADDR_W-1:0]  rd_addr;
    logic [NREAD*WIDTH-1:0]   rd_data;
    logic                     collision;

    modport master (
        output clr, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, collision
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, collision
    );
endinterface

// File: rtl/regfile_mp.sv
// Flop-based multi-port register file with priority writes, optional write-to-read bypass,
// optional registered read, synchronous clear and a registered write-collision flag.
module regfile_mp #(
    parameter int               WIDTH    = 4,
    parameter int               DEPTH    = 4,
    parameter int               ADDR_W   = 2,
    parameter int               NREAD    = 2,
    parameter int               NWRITE   = 2,
    parameter int               BYPASS   = 1,
    parameter int               READ_LAT = 0,
    parameter logic [WIDTH-1:0] INIT     = '0
) (
    input logic          real_clk,
    input logic          real_rst,
    regfile_mp_if.slave  bus
);

    logic [WIDTH-1:0]       mem     [DEPTH];
    logic [WIDTH-1:0]       mem_nxt [DEPTH];
    logic [NWRITE-1:0]      wr_ok;
    logic                   collision_q;
    logic                   collision_nxt;
    logic [NREAD*WIDTH-1:0] rd_v;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // A write port only counts (for commit, bypass and collision) when enabled and in range.
    always_comb begin
        wr_ok = '0;
        for (int k = 0; k < NWRITE; k++)
            wr_ok[k] = bus.wr_en[k] && in_range(bus.wr_addr[k*ADDR_W +: ADDR_W]);
    end

    // Later ports overwrite earlier ones, so the highest-index matching port wins.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_nxt[e] = mem[e];
            for (int k = 0; k < NWRITE; k++)
                if (wr_ok[k] && bus.wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(e))
                    mem_nxt[e] = bus.wr_data[k*WIDTH +: WIDTH];
            if (bus.clr)
                mem_nxt[e] = INIT;
        end
    end

    always_comb begin
        collision_nxt = 1'b0;
        for (int i = 0; i < NWRITE; i++)
            for (int j = i + 1; j < NWRITE; j++)
                if (wr_ok[i] && wr_ok[j] &&
                    bus.wr_addr[i*ADDR_W +: ADDR_W] == bus.wr_addr[j*ADDR_W +: ADDR_W])
                    collision_nxt = 1'b1;
    end

    // Out-of-range read addresses match no entry and no valid write, so they return 0.
    always_comb begin
        rd_v = '0;
        for (int j = 0; j < NREAD; j++) begin
            for (int e = 0; e < DEPTH; e++)
                if (bus.rd_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(e))
                    rd_v[j*WIDTH +: WIDTH] = mem[e];
            if (BYPASS != 0 && !bus.clr)
                for (int k = 0; k < NWRITE; k++)
                    if (wr_ok[k] &&
                        bus.wr_addr[k*ADDR_W +: ADDR_W] == bus.rd_addr[j*ADDR_W +: ADDR_W])
                        rd_v[j*WIDTH +: WIDTH] = bus.wr_data[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            for (int e = 0; e < DEPTH; e++)
                mem[e] <= INIT;
            collision_q <= 1'b0;
        end else begin
            mem         <= mem_nxt;
            collision_q <= collision_nxt;
        end
    end

    assign bus.collision = collision_q;

    generate
        if (READ_LAT != 0) begin : g_rd_reg
            logic [NREAD*WIDTH-1:0] rd_q;
            always_ff @(posedge real_clk or posedge real_rst) begin
                if (real_rst)
                    rd_q <= '0;
                else
                    rd_q <= rd_v;
            end
            assign bus.rd_data = rd_q;
        end else begin : g_rd_comb
            assign bus.rd_data = rd_v;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp: default config, BYPASS=0 with DEPTH=3, and READ_LAT=1.
module tb_regfile_mp;

    typedef struct {
        logic       clr;
        logic [1:0] we;
        logic [1:0] wa0;
        logic [3:0] wd0;
        logic [1:0] wa1;
        logic [3:0] wd1;
        logic [1:0] ra0;
        logic [1:0] ra1;
        logic [3:0] e0;
        logic [3:0] e1;
        logic       ec;
    } vec_t;

    logic real_clk;
    logic real_rst;
    int   n_vec;
    int   n_err;

    vec_t va [15];
    vec_t vb [12];
    vec_t vc [7];

    regfile_mp_if #(.WIDTH(4), .ADDR_W(2), .NREAD(2), .NWRITE(2)) if_a ();
    regfile_mp_if #(.WIDTH(4), .ADDR_W(2), .NREAD(2), .NWRITE(2)) if_b ();
    regfile_mp_if #(.WIDTH(4), .ADDR_W(2), .NREAD(2), .NWRITE(2)) if_c ();

    regfile_mp #(.WIDTH(4), .DEPTH(4), .ADDR_W(2), .NREAD(2), .NWRITE(2),
                 .BYPASS(1), .READ_LAT(0), .INIT(4'h0))
        u_a (.real_clk(real_clk), .real_rst(real_rst), .bus(if_a));

    regfile_mp #(.WIDTH(4), .DEPTH(3), .ADDR_W(2), .NREAD(2), .NWRITE(2),
                 .BYPASS(0), .READ_LAT(0), .INIT(4'h0))
        u_b (.real_clk(real_clk), .real_rst(real_rst), .bus(if_b));

    regfile_mp #(.WIDTH(4), .DEPTH(4), .ADDR_W(2), .NREAD(2), .NWRITE(2),
                 .BYPASS(1), .READ_LAT(1), .INIT(4'h0))
        u_c (.real_clk(real_clk), .real_rst(real_rst), .bus(if_c));

    initial real_clk = 1'b0;
    always #5 real_clk = ~real_clk;

    function automatic vec_t mk(int c, int we, int wa0, int wd0, int wa1, int wd1,
                                int ra0, int ra1, int e0, int e1, int ec);
        vec_t v;
        v.clr = c[0];
        v.we  = we[1:0];
        v.wa0 = wa0[1:0];
        v.wd0 = wd0[3:0];
        v.wa1 = wa1[1:0];
        v.wd1 = wd1[3:0];
        v.ra0 = ra0[1:0];
        v.ra1 = ra1[1:0];
        v.e0  = e0[3:0];
        v.e1  = e1[3:0];
        v.ec  = ec[0];
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply_a(input vec_t v);
        if_a.clr = v.clr; if_a.wr_en = v.we;
        if_a.wr_addr = {v.wa1, v.wa0}; if_a.wr_data = {v.wd1, v.wd0};
        if_a.rd_addr = {v.ra1, v.ra0};
    endtask

    task automatic apply_b(input vec_t v);
        if_b.clr = v.clr; if_b.wr_en = v.we;
        if_b.wr_addr = {v.wa1, v.wa0}; if_b.wr_data = {v.wd1, v.wd0};
        if_b.rd_addr = {v.ra1, v.ra0};
    endtask

    task automatic apply_c(input vec_t v);
        if_c.clr = v.clr; if_c.wr_en = v.we;
        if_c.wr_addr = {v.wa1, v.wa0}; if_c.wr_data = {v.wd1, v.wd0};
        if_c.rd_addr = {v.ra1, v.ra0};
    endtask

    initial begin
        vec_t idle;
        n_vec = 0;
        n_err = 0;
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //        clr we wa0 wd0 wa1 wd1 ra0 ra1 e0  e1  ec
        va[0]  = mk(0, 1, 1, 10, 0, 0,  1, 1, 10, 10, 0);
        va[1]  = mk(0, 0, 0, 0,  0, 0,  1, 1, 10, 10, 0);
        va[2]  = mk(0, 3, 2, 3,  2, 5,  2, 0, 5,  0,  0);
        va[3]  = mk(0, 0, 0, 0,  0, 0,  2, 2, 5,  5,  1);
        va[4]  = mk(0, 3, 2, 3,  3, 5,  2, 3, 3,  5,  0);
        va[5]  = mk(0, 0, 0, 0,  0, 0,  2, 3, 3,  5,  0);
        va[6]  = mk(0, 1, 0, 1,  0, 0,  0, 1, 1,  10, 0);
        va[7]  = mk(0, 1, 0, 7,  0, 0,  0, 0, 7,  7,  0);
        va[8]  = mk(0, 0, 0, 0,  0, 0,  0, 2, 7,  3,  0);
        va[9]  = mk(1, 1, 1, 15, 0, 0,  1, 1, 10, 10, 0);
        va[10] = mk(0, 1, 3, 5,  0, 0,  1, 2, 0,  0,  0);
        va[11] = mk(1, 3, 3, 1,  3, 2,  3, 3, 5,  5,  0);
        va[12] = mk(0, 0, 0, 0,  0, 0,  3, 0, 0,  0,  1);
        va[13] = mk(0, 2, 0, 0,  0, 6,  0, 1, 6,  0,  0);
        va[14] = mk(0, 0, 0, 0,  0, 0,  0, 0, 6,  6,  0);

        vb[0]  = mk(0, 1, 0, 1,  0, 0,  0, 0, 0,  0,  0);
        vb[1]  = mk(0, 1, 0, 7,  0, 0,  0, 1, 1,  0,  0);
        vb[2]  = mk(0, 0, 0, 0,  0, 0,  0, 0, 7,  7,  0);
        vb[3]  = mk(0, 3, 3, 9,  3, 9,  3, 0, 0,  7,  0);
        vb[4]  = mk(0, 0, 0, 0,  0, 0,  3, 3, 0,  0,  0);
        vb[5]  = mk(0, 0, 0, 0,  0, 0,  0, 1, 7,  0,  0);
        vb[6]  = mk(0, 3, 2, 3,  2, 5,  2, 2, 0,  0,  0);
        vb[7]  = mk(0, 0, 0, 0,  0, 0,  2, 1, 5,  0,  1);
        vb[8]  = mk(0, 3, 1, 4,  3, 8,  1, 3, 0,  0,  0);
        vb[9]  = mk(0, 0, 0, 0,  0, 0,  1, 2, 4,  5,  0);
        vb[10] = mk(1, 1, 1, 15, 0, 0,  1, 0, 4,  7,  0);
        vb[11] = mk(0, 0, 0, 0,  0, 0,  1, 0, 0,  0,  0);

        // Expected read values here are those presented one cycle earlier.
        vc[0]  = mk(0, 1, 3, 12, 0, 0,  0, 0, 0,  0,  0);
        vc[1]  = mk(0, 0, 0, 0,  0, 0,  3, 3, 0,  0,  0);
        vc[2]  = mk(0, 0, 0, 0,  0, 0,  0, 1, 12, 12, 0);
        vc[3]  = mk(0, 0, 0, 0,  0, 0,  3, 0, 0,  0,  0);
        vc[4]  = mk(0, 1, 1, 6,  0, 0,  1, 3, 12, 0,  0);
        vc[5]  = mk(0, 2, 0, 0,  2, 2,  2, 2, 6,  12, 0);
        vc[6]  = mk(0, 0, 0, 0,  0, 0,  1, 2, 2,  2,  0);

        real_rst = 1'b1;
        apply_a(idle); apply_b(idle); apply_c(idle);

        // Under reset every address reads 0 and no collision is flagged.
        #2;
        for (int a = 0; a < 4; a++) begin
            if_a.rd_addr = {a[1:0], a[1:0]};
            #1;
            check("rst_rd0", a, if_a.rd_data[3:0], 4'h0);
            check("rst_rd1", a, if_a.rd_data[7:4], 4'h0);
        end
        check("rst_coll_a", 0, {3'b0, if_a.collision}, 4'h0);
        check("rst_coll_b", 0, {3'b0, if_b.collision}, 4'h0);
        check("rst_rdq_c", 0, if_c.rd_data[3:0], 4'h0);
        @(negedge real_clk);
        real_rst = 1'b0;
        @(posedge real_clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            apply_a(va[i]);
            @(negedge real_clk);
            check("a_rd0", i, if_a.rd_data[3:0], va[i].e0);
            check("a_rd1", i, if_a.rd_data[7:4], va[i].e1);
            check("a_coll", i, {3'b0, if_a.collision}, {3'b0, va[i].ec});
            @(posedge real_clk);
            #1;
        end
        apply_a(idle);

        for (int i = 0; i < 12; i++) begin
            apply_b(vb[i]);
            @(negedge real_clk);
            check("b_rd0", i, if_b.rd_data[3:0], vb[i].e0);
            check("b_rd1", i, if_b.rd_data[7:4], vb[i].e1);
            check("b_coll", i, {3'b0, if_b.collision}, {3'b0, vb[i].ec});
            @(posedge real_clk);
            #1;
        end
        apply_b(idle);

        for (int i = 0; i < 7; i++) begin
            apply_c(vc[i]);
            @(negedge real_clk);
            check("c_rd0", i, if_c.rd_data[3:0], vc[i].e0);
            check("c_rd1", i, if_c.rd_data[7:4], vc[i].e1);
            check("c_coll", i, {3'b0, if_c.collision}, {3'b0, vc[i].ec});
            @(posedge real_clk);
            #1;
        end

        // Asynchronous reset between edges with a write pending on instance A.
        apply_c(idle);
        if_c.rd_addr = {2'd3, 2'd3};
        apply_a(mk(0, 1, 2, 9, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check("pre_rst_a", 0, if_a.rd_data[3:0], 4'h6);
        check("pre_rst_c", 0, if_c.rd_data[3:0], 4'h6);
        real_rst = 1'b1;
        #1;
        check("async_rst_a", 0, if_a.rd_data[3:0], 4'h0);
        check("async_rst_c", 0, if_c.rd_data[3:0], 4'h0);
        @(posedge real_clk);
        @(negedge real_clk);
        real_rst = 1'b0;
        apply_a(mk(0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0));
        #1;
        check("rst_drop_wr", 0, if_a.rd_data[3:0], 4'h0);
        check("rst_coll_a2", 0, {3'b0, if_a.collision}, 4'h0);
        @(posedge real_clk);
        #1;
        check("rst_entry3_c", 0, if_c.rd_data[3:0], 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
